// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem request/ready handshake
// and feeds the fetch/decode register, handling stalls, redirects, misses and HLT.
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] PC_INC      = 16'h0002,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter logic [15:0] NOP_INSTR   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic [15:0] curr_pc,
  output logic [15:0] next_pc,
  output logic [15:0] curr_instr,
  output logic        fd_enable,
  output logic        fd_flush,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_MISS  = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state, state_d;
  logic [15:0] pc, pc_d;
  logic        pend, pend_d;
  logic [15:0] pend_pc, pend_pc_d;
  logic [15:0] ibuf, ibuf_d;
  logic [15:0] seq_pc;

  assign seq_pc    = pc + PC_INC;
  assign imem_addr = pc;
  assign curr_pc   = pc;
  assign next_pc   = seq_pc;

  // Next-state and combinational outputs.
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    pend_d     = pend;
    pend_pc_d  = pend_pc;
    ibuf_d     = ibuf;
    imem_req   = 1'b1;
    curr_instr = NOP_INSTR;
    fd_enable  = 1'b1;
    fd_flush   = 1'b0;
    halted     = 1'b0;

    case (state)
      S_FETCH: begin
        if (redirect_valid) begin
          pc_d     = redirect_pc;
          fd_flush = 1'b1;
        end else if (stall) begin
          fd_enable = 1'b0;
        end else if (imem_rdy) begin
          curr_instr = imem_data;
          if (imem_data[15:12] == HALT_OPCODE) state_d = S_HALT;
          else                                 pc_d    = seq_pc;
        end else begin
          state_d = S_MISS;
        end
      end

      S_MISS: begin
        fd_enable = ~stall;
        if (redirect_valid) fd_flush = 1'b1;
        // A redirect seen during the miss makes the returning word wrong-path.
        if (imem_rdy && (pend || redirect_valid)) begin
          pc_d    = redirect_valid ? redirect_pc : pend_pc;
          pend_d  = 1'b0;
          state_d = S_FETCH;
        end else if (redirect_valid) begin
          pend_d    = 1'b1;
          pend_pc_d = redirect_pc;
        end else if (imem_rdy && !stall) begin
          curr_instr = imem_data;
          if (imem_data[15:12] == HALT_OPCODE) begin
            state_d = S_HALT;
          end else begin
            pc_d    = seq_pc;
            state_d = S_FETCH;
          end
        end else if (imem_rdy) begin
          ibuf_d  = imem_data;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        imem_req  = 1'b0;
        fd_enable = ~stall;
        if (redirect_valid) begin
          pc_d     = redirect_pc;
          fd_flush = 1'b1;
          state_d  = S_FETCH;
        end else begin
          curr_instr = ibuf;
          if (!stall) begin
            if (ibuf[15:12] == HALT_OPCODE) begin
              state_d = S_HALT;
            end else begin
              pc_d    = seq_pc;
              state_d = S_FETCH;
            end
          end
        end
      end

      S_HALT: begin
        imem_req  = 1'b0;
        halted    = 1'b1;
        fd_enable = ~stall;
        if (redirect_valid) begin
          pc_d     = redirect_pc;
          fd_flush = 1'b1;
          state_d  = S_FETCH;
        end
      end

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      pend    <= 1'b0;
      pend_pc <= 16'h0000;
      ibuf    <= 16'h0000;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      pend    <= pend_d;
      pend_pc <= pend_pc_d;
      ibuf    <= ibuf_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a driver issues per-cycle vectors and queues
// hand-computed expectations; a negedge monitor pops and compares them.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;
  logic [15:0] curr_pc;
  logic [15:0] next_pc;
  logic [15:0] curr_instr;
  logic        fd_enable;
  logic        fd_flush;
  logic        halted;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] npc;
    logic [15:0] instr;
    logic        en;
    logic        fl;
    logic        hl;
    logic        req;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdy       (imem_rdy),
    .imem_data      (imem_data),
    .curr_pc        (curr_pc),
    .next_pc        (next_pc),
    .curr_instr     (curr_instr),
    .fd_enable      (fd_enable),
    .fd_flush       (fd_flush),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic st, input logic rv, input logic [15:0] rpc,
                     input logic rdy, input logic [15:0] dat,
                     input logic [15:0] epc, input logic [15:0] enpc,
                     input logic [15:0] ein, input logic een, input logic efl,
                     input logic ehl, input logic ereq);
    exp_t e;
    @(posedge clk);
    #1;
    rst            = 1'b0;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_rdy       = rdy;
    imem_data      = dat;
    e.pc = epc; e.npc = enpc; e.instr = ein;
    e.en = een; e.fl = efl; e.hl = ehl; e.req = ereq;
    q.push_back(e);
  endtask

  task automatic reset_cycle();
    @(posedge clk);
    #1;
    rst            = 1'b1;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    imem_rdy       = 1'b1;
    imem_data      = 16'h9999;
  endtask

  // Monitor: the DUT presents a full output set every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (curr_pc !== e.pc || next_pc !== e.npc || curr_instr !== e.instr ||
          fd_enable !== e.en || fd_flush !== e.fl || halted !== e.hl ||
          imem_req !== e.req || imem_addr !== e.pc) begin
        errors++;
        $display("FAIL cycle_%0d: got pc=%h npc=%h addr=%h instr=%h en=%b fl=%b hl=%b req=%b want pc=%h npc=%h addr=%h instr=%h en=%b fl=%b hl=%b req=%b",
                 checks, curr_pc, next_pc, imem_addr, curr_instr, fd_enable, fd_flush,
                 halted, imem_req, e.pc, e.npc, e.pc, e.instr, e.en, e.fl, e.hl, e.req);
      end
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
    imem_rdy = 1'b0; imem_data = 16'h0000;
    repeat (2) @(posedge clk);

    // Sequential fetch after reset, then a 2-cycle stall at 0x0004.
    cyc(0,0,16'h0000,1,16'h1111, 16'h0000,16'h0002,16'h1111,1,0,0,1);
    cyc(0,0,16'h0000,1,16'h2222, 16'h0002,16'h0004,16'h2222,1,0,0,1);
    cyc(1,0,16'h0000,1,16'h3333, 16'h0004,16'h0006,16'h0000,0,0,0,1);
    cyc(1,0,16'h0000,1,16'h3333, 16'h0004,16'h0006,16'h0000,0,0,0,1);
    cyc(0,0,16'h0000,1,16'h3333, 16'h0004,16'h0006,16'h3333,1,0,0,1);
    cyc(0,0,16'h0000,1,16'h4444, 16'h0006,16'h0008,16'h4444,1,0,0,1);
    // Redirects from FETCH, plain and with stall.
    cyc(0,1,16'h0040,1,16'h7777, 16'h0008,16'h000A,16'h0000,1,1,0,1);
    cyc(0,0,16'h0000,1,16'h4040, 16'h0040,16'h0042,16'h4040,1,0,0,1);
    cyc(0,1,16'h0008,1,16'h7777, 16'h0042,16'h0044,16'h0000,1,1,0,1);
    cyc(1,1,16'h0040,1,16'h7777, 16'h0008,16'h000A,16'h0000,1,1,0,1);
    cyc(0,1,16'h0010,1,16'h7777, 16'h0040,16'h0042,16'h0000,1,1,0,1);
    // Three-cycle miss at 0x0010, then delivery.
    cyc(0,0,16'h0000,0,16'hDEAD, 16'h0010,16'h0012,16'h0000,1,0,0,1);
    cyc(0,0,16'h0000,0,16'hDEAD, 16'h0010,16'h0012,16'h0000,1,0,0,1);
    cyc(0,0,16'h0000,0,16'hDEAD, 16'h0010,16'h0012,16'h0000,1,0,0,1);
    cyc(0,0,16'h0000,1,16'h5A5A, 16'h0010,16'h0012,16'h5A5A,1,0,0,1);
    cyc(0,0,16'h0000,1,16'h1212, 16'h0012,16'h0014,16'h1212,1,0,0,1);
    // Miss completes under stall: HOLD then deliver the buffered word.
    cyc(0,0,16'h0000,0,16'hDEAD, 16'h0014,16'h0016,16'h0000,1,0,0,1);
    cyc(1,0,16'h0000,1,16'h5A5A, 16'h0014,16'h0016,16'h0000,0,0,0,1);
    cyc(1,0,16'h0000,0,16'hDEAD, 16'h0014,16'h0016,16'h5A5A,0,0,0,0);
    cyc(0,0,16'h0000,0,16'hDEAD, 16'h0014,16'h0016,16'h5A5A,1,0,0,0);
    cyc(0,0,16'h0000,1,16'h1616, 16'h0016,16'h0018,16'h1616,1,0,0,1);
    // Redirect during a miss: address held, returning data discarded.
    cyc(0,1,16'h0010,1,16'h7777, 16'h0018,16'h001A,16'h0000,1,1,0,1);
    cyc(0,0,16'h0000,0,16'hDEAD, 16'h0010,16'h0012,16'h0000,1,0,0,1);
    cyc(0,1,16'h0080,0,16'hDEAD, 16'h0010,16'h0012,16'h0000,1,1,0,1);
    cyc(0,0,16'h0000,0,16'hDEAD, 16'h0010,16'h0012,16'h0000,1,0,0,1);
    cyc(0,0,16'h0000,1,16'hBEEF, 16'h0010,16'h0012,16'h0000,1,0,0,1);
    cyc(0,0,16'h0000,1,16'h8080, 16'h0080,16'h0082,16'h8080,1,0,0,1);
    // Reset in the middle of a miss.
    cyc(0,0,16'h0000,0,16'hDEAD, 16'h0082,16'h0084,16'h0000,1,0,0,1);
    reset_cycle();
    cyc(0,0,16'h0000,1,16'h0101, 16'h0000,16'h0002,16'h0101,1,0,0,1);
    // HLT at 0x0020, halt behaviour, then wrong-path recovery to 0x0030.
    cyc(0,1,16'h0020,1,16'h7777, 16'h0002,16'h0004,16'h0000,1,1,0,1);
    cyc(0,0,16'h0000,1,16'hF000, 16'h0020,16'h0022,16'hF000,1,0,0,1);
    cyc(0,0,16'h0000,1,16'hF000, 16'h0020,16'h0022,16'h0000,1,0,1,0);
    cyc(1,0,16'h0000,1,16'hF000, 16'h0020,16'h0022,16'h0000,0,0,1,0);
    cyc(0,1,16'h0030,1,16'hF000, 16'h0020,16'h0022,16'h0000,1,1,1,0);
    cyc(0,0,16'h0000,1,16'h3030, 16'h0030,16'h0032,16'h3030,1,0,0,1);
    // PC wrap from 0xFFFE.
    cyc(0,1,16'hFFFE,1,16'h7777, 16'h0032,16'h0034,16'h0000,1,1,0,1);
    cyc(0,0,16'h0000,1,16'hEEEE, 16'hFFFE,16'h0000,16'hEEEE,1,0,0,1);
    cyc(0,0,16'h0000,1,16'h0101, 16'h0000,16'h0002,16'h0101,1,0,0,1);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
